// File: rtl/fpga_input_char_pkg.sv
// rtl/fpga_input_char_pkg.sv - shared field positions, ack opcode and FSM states for the char transmitter
package fpga_input_char_pkg;

    localparam int OUT_VALID_BIT = 31;
    localparam int OUT_SEQ_BIT   = 30;
    localparam int OUT_CHAR_LSB  = 0;
    localparam int CHAR_W        = 8;

    localparam int ACK_OP_MSB  = 31;
    localparam int ACK_OP_LSB  = 24;
    localparam int ACK_SEQ_BIT = 8;

    localparam logic [7:0] ACK_OP_DEFAULT = 8'hA5;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } tx_state_e;

    function automatic logic [31:0] pack_out_word(input logic valid, input logic seq,
                                                  input logic [CHAR_W-1:0] ch);
        logic [31:0] w;
        w = '0;
        w[OUT_VALID_BIT] = valid;
        w[OUT_SEQ_BIT]   = seq;
        w[OUT_CHAR_LSB +: CHAR_W] = ch;
        return w;
    endfunction

endpackage

// File: rtl/fpga_char_sync_fifo.sv
// rtl/fpga_char_sync_fifo.sv - DEPTH x 8 synchronous character FIFO with extra-MSB pointers
module fpga_char_sync_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     core_clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic [7:0]  mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign do_pop  = pop & ~empty;
    // A simultaneous pop frees the slot being written, so a push at full still lands.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge core_clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge core_clk) begin
        if (!rst && do_push) mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign pop_data = mem[rd_ptr_q[AW-1:0]];
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count    = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/fpga_input_char_tx.sv
// rtl/fpga_input_char_tx.sv - queues host characters and presents them one at a time on a firmware-acked input wire
module fpga_input_char_tx
    import fpga_input_char_pkg::*;
#(
    parameter int         DEPTH  = 16,
    parameter logic [7:0] ACK_OP = ACK_OP_DEFAULT
) (
    input  logic                   core_clk,
    input  logic                   rst,
    input  logic                   host_wr_en,
    input  logic [7:0]             host_wr_data,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [31:0]            out_wire,
    input  logic                   fw_wr_en,
    input  logic [31:0]            fw_wr_data,
    input  logic [15:0]            timeout_div,
    output logic                   overflow_err,
    output logic                   timeout_err,
    input  logic                   clr_err
);

    tx_state_e   state_q;
    tx_state_e   state_d;
    logic        pop;
    logic        ack;
    logic        timeout;
    logic        ovf_evt;
    logic [7:0]  fifo_rd_data;
    logic [15:0] cnt_q;
    logic        seq_q;
    logic        out_seq_q;
    logic        valid_q;
    logic [7:0]  char_q;
    logic        unused_fw_bits;

    assign unused_fw_bits = ^{fw_wr_data[ACK_OP_LSB-1:ACK_SEQ_BIT+1], fw_wr_data[ACK_SEQ_BIT-1:0]};

    fpga_char_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .core_clk  (core_clk),
        .rst       (rst),
        .push      (host_wr_en),
        .push_data (host_wr_data),
        .pop       (pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        ack     = 1'b0;
        timeout = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                ack = fw_wr_en && (fw_wr_data[ACK_OP_MSB:ACK_OP_LSB] == ACK_OP)
                      && (fw_wr_data[ACK_SEQ_BIT] == seq_q);
                // Fires on the edge that would bring the counter up to timeout_div; ack wins a tie.
                timeout = !ack && (timeout_div != 16'd0)
                          && (({1'b0, cnt_q} + 17'd1) == {1'b0, timeout_div});
                if (ack || timeout) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // The word shows the parity before the toggle; firmware acks by echoing the toggled seq_q.
    always_ff @(posedge core_clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            seq_q     <= 1'b0;
            out_seq_q <= 1'b0;
            char_q    <= 8'h00;
            cnt_q     <= 16'd0;
        end else if (pop) begin
            char_q    <= fifo_rd_data;
            out_seq_q <= seq_q;
            seq_q     <= ~seq_q;
            valid_q   <= 1'b1;
            cnt_q     <= 16'd0;
        end else if (ack || timeout) begin
            valid_q   <= 1'b0;
        end else if (state_q == ST_PRESENT) begin
            cnt_q     <= cnt_q + 16'd1;
        end
    end

    assign ovf_evt = host_wr_en & fifo_full & ~pop;

    always_ff @(posedge core_clk) begin
        if (rst) begin
            overflow_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            if (ovf_evt)      overflow_err <= 1'b1;
            else if (clr_err) overflow_err <= 1'b0;
            if (timeout)      timeout_err  <= 1'b1;
            else if (clr_err) timeout_err  <= 1'b0;
        end
    end

    assign out_wire = pack_out_word(valid_q, out_seq_q, char_q);

endmodule

// File: doc/fpga_input_char_tx.md
FPGA_INPUT_CHAR_TX -- requirements
Module: fpga_input_char_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning character FIFO depth (power of two, 4..64).
REQ-002 SHALL have parameter ACK_OP, default 8'hA5, meaning the firmware acknowledge opcode expected in fw_wr_data[31:24].
REQ-003 SHALL have port core_clk  input  1  meaning the single block clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, synchronous to core_clk and active-high.
REQ-005 SHALL have port host_wr_en  input  1  meaning host push strobe, one cycle per character.
REQ-006 SHALL have port host_wr_data  input  8  meaning host character to push.
REQ-007 SHALL have port fifo_full, fifo_empty  output  1 each  meaning FIFO status.
REQ-008 SHALL have port fifo_count  output  $clog2(DEPTH)+1  meaning current occupancy.
REQ-009 SHALL have port out_wire  output  32  meaning word driven to Caliptra generic input wire 0.
REQ-010 SHALL have port fw_wr_en  input  1  meaning firmware write strobe on generic output wire 0.
REQ-011 SHALL have port fw_wr_data  input  32  meaning firmware-written value on generic output wire 0.
REQ-012 SHALL have port timeout_div  input  16  meaning ack timeout in cycles; 0 disables the timeout.
REQ-013 SHALL have ports overflow_err, timeout_err  output  1 each  meaning sticky error flags; clr_err  input  1  clears both.

Function
REQ-014 out_wire layout SHALL be: [31] valid, [30] seq, [29:8] zero, [7:0] char.
REQ-015 Push SHALL occur when host_wr_en=1 and fifo_full=0; when host_wr_en=1 and fifo_full=1 the character SHALL be dropped and overflow_err set.
REQ-016 A push and a pop in the same cycle SHALL both take effect; fifo_count SHALL be unchanged, including at full.
REQ-017 FSM states SHALL be IDLE and PRESENT.
REQ-018 In IDLE with fifo_empty=0, the block SHALL pop the head, latch the char, toggle seq, set valid=1 and enter PRESENT on the same edge.
REQ-019 A character pushed into an empty FIFO at edge N SHALL appear on out_wire with valid=1 after edge N+1.
REQ-020 In PRESENT, an ack SHALL be fw_wr_en=1, fw_wr_data[31:24]=ACK_OP and fw_wr_data[8]=seq; on an ack the block SHALL clear valid and return to IDLE.
REQ-021 A firmware write with the wrong opcode or a mismatched seq SHALL be ignored.
REQ-022 Between consecutive characters valid SHALL be low for exactly one cycle.
REQ-023 The PRESENT cycle counter SHALL reset on entry to PRESENT.
REQ-024 When timeout_div is nonzero and the counter reaches timeout_div, the block SHALL set timeout_err, clear valid, discard the char and go to IDLE.
REQ-025 If an ack and the timeout occur in the same cycle, the ack SHALL win and timeout_err SHALL NOT be set.
REQ-026 clr_err=1 SHALL clear both sticky flags, and an error event in the same cycle SHALL take priority and set its flag.
REQ-027 The FIFO read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from the extra pointer MSB.

Reset
REQ-028 On rst=1 the block SHALL set FSM=IDLE, pointers=0, fifo_count=0, fifo_empty=1, fifo_full=0, out_wire=32'h0 (seq=0), both error flags=0, and the counter to 0.
REQ-029 rst asserted in PRESENT SHALL discard the presented and all queued characters; FIFO storage contents SHALL NOT be reset.

Structure
REQ-030 The out_wire bit positions, ACK_OP default and FSM state enum SHALL live in a shared package, fpga_input_char_pkg.
REQ-031 The FIFO SHALL be one sub-module, fpga_char_sync_fifo (DEPTH x 8, push/pop/count/full/empty); the FSM and timeout logic SHALL be in the top module.

Verification
REQ-032 The bench SHALL push 8'h41 with fw idle; required: out_wire=32'h8000_0041 one cycle after the push edge, then fw writes 32'hA500_0100, and the next cycle out_wire[31]=0.
REQ-033 The bench SHALL push "AB" back-to-back and ack each with the correct seq; required: 32'h8000_0041, one cycle valid=0, then 32'hC000_0042.
REQ-034 The bench SHALL ack with seq=0 while seq=1, then with opcode 8'h5A; required: both ignored, valid stays 1 and the FSM stays in PRESENT.
REQ-035 With DEPTH=16, one char presented and no ack, the bench SHALL push 17 more; required: fifo_full=1, fifo_count=16, overflow_err=1, last char dropped.
REQ-036 The bench SHALL set timeout_div=10 with no ack; required: timeout_err=1 and valid=0 after 10 PRESENT cycles, and the next char presented with seq toggled.
REQ-037 The bench SHALL assert rst while in PRESENT with 3 chars queued; required: out_wire=0, fifo_empty=1, and the next push is presented with seq=1.
